// File: rtl/acorn128_step_ctrl.sv
// Phase sequencer for the ACORN-128 state-update stage: emits ca/cb/m per step,
// forms ciphertext from the returned keystream bit and collects the 128-bit tag.
module acorn128_step_ctrl #(
  parameter int INIT_STEPS  = 1792,
  parameter int PAD_STEPS   = 256,
  parameter int FINAL_STEPS = 768,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ad_valid,
  input  logic             ad_bit,
  output logic             ad_ready,
  input  logic             msg_valid,
  input  logic             msg_bit,
  output logic             msg_ready,
  input  logic             ks_in,
  output logic             upd_en,
  output logic             ca_out,
  output logic             cb_out,
  output logic             mbit_out,
  output logic             ct_valid,
  output logic             ct_bit,
  output logic [127:0]     tag,
  output logic             tag_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_ADPAD, S_ENC, S_ENCPAD, S_FINAL, S_DONE
  } state_t;

  localparam logic [10:0] INIT_LAST  = 11'(INIT_STEPS - 1);
  localparam logic [10:0] PAD_LAST   = 11'(PAD_STEPS - 1);
  localparam logic [10:0] FINAL_LAST = 11'(FINAL_STEPS - 1);
  localparam logic [10:0] TAG_FIRST  = 11'(FINAL_STEPS - 128);

  state_t             state_q, state_d;
  logic [10:0]        cnt_q;
  logic [127:0]       tag_q;
  logic [127:0]       key_q, iv_q;
  logic [LEN_W-1:0]   ad_len_q, msg_len_q;
  logic               start_acc;
  logic               step_last;
  logic               init_m;
  logic [6:0]         tag_idx;

  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
  assign tag_idx   = 7'(cnt_q - TAG_FIRST);

  assign tag       = tag_q;
  assign tag_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

  // Key/IV loading: key, then IV, then key with bit 0 flipped once, then key repeating.
  always_comb begin
    if (cnt_q < 11'd128)       init_m = key_q[cnt_q[6:0]];
    else if (cnt_q < 11'd256)  init_m = iv_q[cnt_q[6:0]];
    else if (cnt_q == 11'd256) init_m = ~key_q[0];
    else                       init_m = key_q[cnt_q[6:0]];
  end

  always_comb begin
    upd_en    = 1'b0;
    ca_out    = 1'b0;
    cb_out    = 1'b0;
    mbit_out  = 1'b0;
    ad_ready  = 1'b0;
    msg_ready = 1'b0;
    ct_valid  = 1'b0;
    ct_bit    = 1'b0;
    case (state_q)
      S_INIT: begin
        upd_en   = 1'b1;
        ca_out   = 1'b1;
        cb_out   = 1'b1;
        mbit_out = init_m;
      end
      S_AD: begin
        upd_en   = ad_valid;
        ad_ready = ad_valid;
        if (ad_valid) begin
          ca_out   = 1'b1;
          cb_out   = 1'b1;
          mbit_out = ad_bit;
        end
      end
      S_ADPAD: begin
        upd_en   = 1'b1;
        ca_out   = (cnt_q < 11'd128);
        cb_out   = 1'b1;
        mbit_out = (cnt_q == 11'd0);
      end
      S_ENC: begin
        upd_en    = msg_valid;
        msg_ready = msg_valid;
        ct_valid  = msg_valid;
        if (msg_valid) begin
          ca_out   = 1'b1;
          mbit_out = msg_bit;
          ct_bit   = msg_bit ^ ks_in;
        end
      end
      S_ENCPAD: begin
        upd_en   = 1'b1;
        ca_out   = (cnt_q < 11'd128);
        mbit_out = (cnt_q == 11'd0);
      end
      S_FINAL: begin
        upd_en = 1'b1;
        ca_out = 1'b1;
        cb_out = 1'b1;
      end
      default: ;
    endcase
  end

  // Zero-length AD / message phases are skipped entirely, so no idle step is spent on them.
  always_comb begin
    step_last = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_INIT: begin
        step_last = (cnt_q == INIT_LAST);
        state_d   = (ad_len_q == '0) ? S_ADPAD : S_AD;
      end
      S_AD: begin
        step_last = (LEN_W'(cnt_q) == ad_len_q - LEN_W'(1));
        state_d   = S_ADPAD;
      end
      S_ADPAD: begin
        step_last = (cnt_q == PAD_LAST);
        state_d   = (msg_len_q == '0) ? S_ENCPAD : S_ENC;
      end
      S_ENC: begin
        step_last = (LEN_W'(cnt_q) == msg_len_q - LEN_W'(1));
        state_d   = S_ENCPAD;
      end
      S_ENCPAD: begin
        step_last = (cnt_q == PAD_LAST);
        state_d   = S_FINAL;
      end
      S_FINAL: begin
        step_last = (cnt_q == FINAL_LAST);
        state_d   = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else if (start_acc) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else if (upd_en) begin
      if (state_q == S_FINAL && cnt_q >= TAG_FIRST) tag_q[tag_idx] <= ks_in;
      if (step_last) begin
        state_q <= state_d;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 11'd1;
      end
    end
  end

  // Run parameters are only sampled when a run is accepted; the inputs may change afterwards.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      key_q     <= key;
      iv_q      <= iv;
      ad_len_q  <= ad_len;
      msg_len_q <= msg_len;
    end
  end

endmodule

// File: tb/tb_acorn128_step_ctrl.sv
// Self-checking bench for acorn128_step_ctrl: table of runs checked against a step-list model,
// plus hand-written reset and start-while-busy sequences.
module tb_acorn128_step_ctrl;
  localparam int LEN_W      = 16;
  localparam int CYC_BUDGET = 20000;
  localparam int PH_INIT = 0, PH_AD = 1, PH_ADPAD = 2, PH_ENC = 3, PH_ENCPAD = 4, PH_FINAL = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [127:0]     key = '0, iv = '0;
  logic [LEN_W-1:0] ad_len = '0, msg_len = '0;
  logic             ad_valid = 1'b0, ad_bit = 1'b0, msg_valid = 1'b0, msg_bit = 1'b0, ks_in = 1'b0;
  logic             ad_ready, msg_ready, upd_en, ca_out, cb_out, mbit_out, ct_valid, ct_bit;
  logic             tag_valid, busy;
  logic [127:0]     tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  acorn128_step_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .iv(iv),
    .ad_len(ad_len), .msg_len(msg_len),
    .ad_valid(ad_valid), .ad_bit(ad_bit), .ad_ready(ad_ready),
    .msg_valid(msg_valid), .msg_bit(msg_bit), .msg_ready(msg_ready),
    .ks_in(ks_in), .upd_en(upd_en), .ca_out(ca_out), .cb_out(cb_out), .mbit_out(mbit_out),
    .ct_valid(ct_valid), .ct_bit(ct_bit), .tag(tag), .tag_valid(tag_valid), .busy(busy)
  );

  typedef struct {
    int ph;
    int idx;
    bit ca;
    bit cb;
    bit m;
  } step_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    int           ad_len;
    int           msg_len;
    logic [63:0]  ad;
    logic [63:0]  msg;
    int           gap;      // 0 always valid, 1 alternate 1,0,1.., 2 random
    int           ksm;      // 0 ks=1, 1 random, 2 FINAL-local step parity
    bit           poke;     // scramble start/key/iv/lengths while busy
    int           exp_upd;
    int           exp_adcyc;
    bit           chk_ct;
    logic [63:0]  exp_ct;
    bit           chk_tag;
    logic [127:0] exp_tag;
  } vec_t;

  step_t steps[$];
  vec_t  tbl[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] obs();
    return {upd_en, ca_out, cb_out, mbit_out, ad_ready, msg_ready, ct_valid, ct_bit, busy, tag_valid};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected step list of one run, phase by phase.
  task automatic build_model(input vec_t v);
    steps.delete();
    for (int i = 0; i < 1792; i++) begin
      bit m;
      if (i < 128)       m = v.key[i];
      else if (i < 256)  m = v.iv[i - 128];
      else if (i == 256) m = !v.key[0];
      else               m = v.key[i % 128];
      steps.push_back('{PH_INIT, i, 1'b1, 1'b1, m});
    end
    for (int i = 0; i < v.ad_len; i++)  steps.push_back('{PH_AD, i, 1'b1, 1'b1, v.ad[i]});
    for (int i = 0; i < 256; i++)       steps.push_back('{PH_ADPAD, i, i < 128, 1'b1, i == 0});
    for (int i = 0; i < v.msg_len; i++) steps.push_back('{PH_ENC, i, 1'b1, 1'b0, v.msg[i]});
    for (int i = 0; i < 256; i++)       steps.push_back('{PH_ENCPAD, i, i < 128, 1'b0, i == 0});
    for (int i = 0; i < 768; i++)       steps.push_back('{PH_FINAL, i, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic run_txn(input vec_t v, input int vi, input int abort_at);
    int k = 0, cyc = 0, errs = 0, first_bad = -1, upd_cnt = 0, adcyc = 0, msgcyc = 0;
    logic [63:0]  ct_obs = '0, ct_mod = '0;
    logic [127:0] tag_mod = '0;
    build_model(v);
    key = v.key; iv = v.iv;
    ad_len = LEN_W'(v.ad_len); msg_len = LEN_W'(v.msg_len);
    ad_valid = 1'b0; msg_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < steps.size() && k != abort_at && cyc < CYC_BUDGET) begin
      step_t      s;
      logic [9:0] ev;
      bit         eu, in_ad, in_enc;
      s = steps[k];
      in_ad  = (s.ph == PH_AD);
      in_enc = (s.ph == PH_ENC);
      if (v.gap == 0) begin
        ad_valid = 1'b1; msg_valid = 1'b1;
      end else if (v.gap == 1) begin
        ad_valid = (adcyc % 2 == 0); msg_valid = (msgcyc % 2 == 0);
      end else begin
        ad_valid = 1'($urandom_range(0, 1)); msg_valid = 1'($urandom_range(0, 1));
      end
      if (in_ad)  ad_bit = v.ad[s.idx];   else ad_bit = 1'($urandom);
      if (in_enc) msg_bit = v.msg[s.idx]; else msg_bit = 1'($urandom);
      case (v.ksm)
        0:       ks_in = 1'b1;
        2:       ks_in = (s.ph == PH_FINAL) ? ((s.idx % 2) != 0) : 1'($urandom);
        default: ks_in = 1'($urandom);
      endcase
      if (v.poke) begin
        start = 1'($urandom); key = r128(); iv = r128();
        ad_len = LEN_W'($urandom); msg_len = LEN_W'($urandom);
      end
      #2;
      eu = in_ad ? ad_valid : (in_enc ? msg_valid : 1'b1);
      ev = {eu, eu & s.ca, eu & s.cb, eu & s.m, in_ad & ad_valid, in_enc & msg_valid,
            in_enc & msg_valid, in_enc & msg_valid & (msg_bit ^ ks_in), 1'b1, 1'b0};
      if (obs() !== ev || (cyc == 0 && tag !== '0)) begin
        errs++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (upd_en) upd_cnt++;
      if (eu) begin
        if (in_enc) begin
          ct_obs[s.idx] = ct_bit;
          ct_mod[s.idx] = msg_bit ^ ks_in;
        end
        if (s.ph == PH_FINAL && s.idx >= 640) tag_mod[s.idx - 640] = ks_in;
        k++;
      end
      if (in_ad)  adcyc++;
      if (in_enc) msgcyc++;
      cyc++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    ad_valid = 1'b1; msg_valid = 1'b1; ks_in = 1'b1; start = 1'b0;
    if (abort_at < 0) begin
      check($sformatf("v%0d steps completed", vi), 128'(k), 128'(steps.size()));
      check($sformatf("v%0d per-cycle outputs, errors (first bad cycle %0d)", vi, first_bad),
            128'(errs), 128'(0));
      check($sformatf("v%0d upd_en count", vi), 128'(upd_cnt), 128'(v.exp_upd));
      if (v.exp_adcyc >= 0) check($sformatf("v%0d AD cycles", vi), 128'(adcyc), 128'(v.exp_adcyc));
      check($sformatf("v%0d ct bits", vi), 128'(ct_obs), 128'(v.chk_ct ? v.exp_ct : ct_mod));
      #2;
      check($sformatf("v%0d DONE outputs", vi), 128'(obs()), 128'(10'b00_0000_0001));
      check($sformatf("v%0d tag", vi), tag, v.chk_tag ? v.exp_tag : tag_mod);
      repeat (3) @(posedge clk);
      #3;
      check($sformatf("v%0d tag held in DONE", vi), {tag[126:0], tag_valid},
            {(v.chk_tag ? v.exp_tag[126:0] : tag_mod[126:0]), 1'b1});
    end
  endtask

  function automatic vec_t mk(logic [127:0] k, logic [127:0] i, int al, int ml,
                              logic [63:0] ad, logic [63:0] msg, int gap, int ksm, bit poke,
                              int eupd, int eadc, bit cct, logic [63:0] ect, bit ctg,
                              logic [127:0] etag);
    vec_t v;
    v.key = k; v.iv = i; v.ad_len = al; v.msg_len = ml; v.ad = ad; v.msg = msg;
    v.gap = gap; v.ksm = ksm; v.poke = poke; v.exp_upd = eupd; v.exp_adcyc = eadc;
    v.chk_ct = cct; v.exp_ct = ect; v.chk_tag = ctg; v.exp_tag = etag;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int al, ml;
    vec_t rv;
    al = $urandom_range(1, 64);
    ml = $urandom_range(1, 64);
    tbl[0] = mk('0, '0, 0, 0, '0, '0, 0, 1, 1'b0, 3072, -1, 1'b0, '0, 1'b0, '0);
    tbl[1] = mk(r128(), r128(), 3, 0, 64'b101, '0, 1, 1, 1'b0, 3075, 5, 1'b0, '0, 1'b0, '0);
    tbl[2] = mk(r128(), r128(), 0, 8, '0, 64'hA5, 0, 0, 1'b0, 3080, -1, 1'b1, 64'h5A,
                1'b1, {128{1'b1}});
    tbl[3] = mk(r128(), r128(), 5, 12, {$urandom, $urandom}, {$urandom, $urandom}, 2, 2, 1'b0,
                3089, -1, 1'b0, '0, 1'b1, {64{2'b10}});
    tbl[4] = mk(r128(), r128(), 7, 9, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1, 1'b1,
                3088, -1, 1'b0, '0, 1'b0, '0);
    tbl[5] = mk(r128(), r128(), al, ml, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1, 1'b0,
                3072 + al + ml, -1, 1'b0, '0, 1'b0, '0);

    ad_valid = 1'b1; msg_valid = 1'b1; ks_in = 1'b1;
    #22;
    check("reset outputs", 128'(obs()), 128'(0));
    check("reset tag", tag, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #3;
    check("idle after reset release", 128'(obs()), 128'(0));
    #1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i], i, -1);

    // Abort 700 steps into FINAL (tag partly filled), then reset asynchronously mid-cycle.
    rv = mk(r128(), r128(), 0, 0, '0, '0, 0, 1, 1'b0, 3072, -1, 1'b0, '0, 1'b0, '0);
    run_txn(rv, 6, 1792 + 256 + 256 + 700);
    check("busy before abort", 128'(busy), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-FINAL outputs", 128'(obs()), 128'(0));
    check("reset mid-FINAL tag", tag, '0);
    @(posedge clk); #3;
    check("reset mid-FINAL next cycle outputs", 128'(obs()), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(tbl[5], 7, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
